axis_operand_packer: RTL
========================

Name: axis_operand_packer

Overview:
- AXI-Stream transmitter-side block that feeds the streaming adder wrapper.
- Takes a 32-bit word stream from upstream, such as a DMA MM2S channel.
- Pairs consecutive words into one 64-bit operand beat: the first word goes to the upper half (operand a), the second to the lower half (operand b).
- Emits the beat on an AXI-Stream master with full tvalid/tready handshake and tlast propagation.
- Pads odd-length packets with a zero b operand.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, width of each input word / single operand.
- C_M_AXIS_TDATA_WIDTH, 2*C_S_AXIS_TDATA_WIDTH, width of the packed output beat.
- CNT_WIDTH, 16, width of the sent-beat counter.

Ports:
- aclk  in  1  the single clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  input operand word.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  block can accept a word.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  packed operand pair {a,b}.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts beat.
- m_axis_tlast  out  1  last beat of packet.
- pad_event  out  1  one-cycle pulse when a padded beat is loaded.
- beats_sent  out  CNT_WIDTH  count of completed output handshakes.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Clock port is aclk, reset port is areset.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pad_event=0, beats_sent=0, hold register=0, state=HI. Any partial pair is discarded.
- Definitions:
  - acc = s_axis_tvalid & s_axis_tready.
  - slot_free = !m_axis_tvalid | m_axis_tready.
  - s_axis_tready = slot_free in both states. It is combinational on the registered tvalid and m_axis_tready, never on s_axis_tvalid or s_axis_tlast.
- State HI (expecting operand a):
  - acc & !s_axis_tlast: hold <= s_axis_tdata; go to LO; no output load.
  - acc & s_axis_tlast: load m_axis_tdata <= {s_axis_tdata, zero}, m_axis_tvalid <= 1, m_axis_tlast <= 1, pad_event <= 1; stay in HI.
- State LO (expecting operand b):
  - acc: load m_axis_tdata <= {hold, s_axis_tdata}, m_axis_tvalid <= 1, m_axis_tlast <= s_axis_tlast; go to HI.
- Output register:
  - Loads only when slot_free, guaranteed by the tready rule.
  - If m_axis_tvalid & m_axis_tready and no load in the same cycle: m_axis_tvalid <= 0, m_axis_tlast <= 0; m_axis_tdata holds its value.
  - Simultaneous consume and load: the new beat replaces the old one, and tvalid stays 1.
- Stability: while m_axis_tvalid & !m_axis_tready, m_axis_tdata and m_axis_tlast are held constant and s_axis_tready=0.
- Latency: beat is valid one cycle after the cycle in which its second word (or padded single word) is accepted.
- Throughput: one output beat per two accepted words. The input runs at one word per cycle when downstream is always ready.
- pad_event: asserted for exactly the cycle after the padded load, 0 otherwise.
- beats_sent: +1 on each m_axis_tvalid & m_axis_tready; wraps modulo 2^CNT_WIDTH; no saturation.
- State LO with hold pending while s_axis_tvalid=0: waits indefinitely with no timeout.
- s_axis_tlast in LO ends the packet normally with no pad.
- The next word after any tlast is always an operand a.
- Reset asserted mid-pair or with a pending output beat: the beat is dropped, tvalid falls the next cycle, and the counter clears.

Test Plan:
1. Reset, then words 0x00000001, 0x00000002 (tlast), m_axis_tready=1 -> single beat 0x00000001_00000002 with tlast=1, tvalid high exactly one cycle, appearing the cycle after the second accept; beats_sent=1.
2. Backpressure: beat {0xA,0xB} pending with m_axis_tready=0 for 5 cycles -> s_axis_tready=0 and tdata/tlast stable throughout; on release the beat transfers and s_axis_tready rises the same cycle.
3. Odd packet A=0x11, B=0x22, C=0x33 (tlast) -> beats 0x00000011_00000022 (tlast=0), then 0x00000033_00000000 (tlast=1); pad_event pulses exactly once.
4. Streaming 8 words 1..8 with tvalid and m_axis_tready held high, tlast on word 8 -> beats {1,2},{3,4},{5,6},{7,8}, tlast only on the 4th, no input stalls, beats_sent=4.
5. Reset mid-pair: accept 0xDEAD, pulse areset for 1 cycle, then send 0x1, 0x2 (tlast) -> only beat 0x00000001_00000002; 0xDEAD never appears.
6. CNT_WIDTH=2, send 5 complete pairs -> beats_sent reads 1 after the 5th handshake (wrap).

Source files
------------

// File: rtl/axis_operand_packer.sv
// axis_operand_packer
// Pairs consecutive 32-bit words from an AXI-Stream slave into one 64-bit
// operand beat {a, b} on an AXI-Stream master. The first word of a pair is
// operand a (upper half) and the second is operand b (lower half). A packet
// that ends on an operand a is padded with a zero b operand and flagged
// through pad_event. beats_sent counts completed output handshakes.
module axis_operand_packer #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 2 * C_S_AXIS_TDATA_WIDTH,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            pad_event,
  output logic [CNT_WIDTH-1:0]            beats_sent
);

  typedef enum logic {
    ST_HI,
    ST_LO
  } state_t;

  state_t                          state, state_next;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] hold_q, hold_next;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_next;
  logic                            tvalid_q, tvalid_next;
  logic                            tlast_q, tlast_next;
  logic                            pad_q, pad_next;
  logic [CNT_WIDTH-1:0]            cnt_q;
  logic                            slot_free;
  logic                            acc;

  // The output slot is free when it is empty or being drained this cycle;
  // tready depends only on registered state and downstream ready.
  always_comb begin
    slot_free     = !tvalid_q || m_axis_tready;
    s_axis_tready = slot_free;
    acc           = s_axis_tvalid && slot_free;
  end

  // Next-state and output-register logic: a load always wins over a drain,
  // so a simultaneous consume and load keeps tvalid high with the new beat.
  always_comb begin
    state_next  = state;
    hold_next   = hold_q;
    tdata_next  = tdata_q;
    tvalid_next = tvalid_q;
    tlast_next  = tlast_q;
    pad_next    = 1'b0;

    if (tvalid_q && m_axis_tready) begin
      tvalid_next = 1'b0;
      tlast_next  = 1'b0;
    end

    unique case (state)
      ST_HI: begin
        if (acc) begin
          if (s_axis_tlast) begin
            tdata_next  = {s_axis_tdata, {C_S_AXIS_TDATA_WIDTH{1'b0}}};
            tvalid_next = 1'b1;
            tlast_next  = 1'b1;
            pad_next    = 1'b1;
          end else begin
            hold_next  = s_axis_tdata;
            state_next = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (acc) begin
          tdata_next  = {hold_q, s_axis_tdata};
          tvalid_next = 1'b1;
          tlast_next  = s_axis_tlast;
          state_next  = ST_HI;
        end
      end
      default: state_next = ST_HI;
    endcase
  end

  // State, hold and output registers; reset drops any partial pair or beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_HI;
      hold_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      pad_q    <= 1'b0;
    end else begin
      state    <= state_next;
      hold_q   <= hold_next;
      tdata_q  <= tdata_next;
      tvalid_q <= tvalid_next;
      tlast_q  <= tlast_next;
      pad_q    <= pad_next;
    end
  end

  // Sent-beat counter, wrapping naturally at its width.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q <= '0;
    end else if (tvalid_q && m_axis_tready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pad_event     = pad_q;
  assign beats_sent    = cnt_q;

endmodule
